onehot_request_arbiter: RTL and testbench

ONEHOT_REQUEST_ARBITER -- requirements
Module: onehot_request_arbiter

---
 rtl/arb_pkg.sv | 13 +
 rtl/onehot_request_arbiter_rr_pick.sv | 37 +++
 rtl/onehot_request_arbiter.sv | 118 +++++++++++
 tb/tb_onehot_request_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the one-hot request arbiter.
//   NUM_REQ : number of request lines (fixed at 8, matches an 8-to-3 encoder)
//   PTR_W   : width of the round-robin pointer / grant index
//   state_t : arbiter FSM states (IDLE = 0, GRANT = 1)
package arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int PTR_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/onehot_request_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Finds the first set bit of pending, searching upward from ptr and
// wrapping from the top bit back to bit 0.
// Ports:
//   pending : in  [NUM_REQ-1:0] candidate request bits
//   ptr     : in  [PTR_W-1:0]   search start position
//   onehot  : out [NUM_REQ-1:0] one-hot of the selected bit (0 if none)
//   index   : out [PTR_W-1:0]   binary index of the selected bit
//   any     : out               at least one pending bit was set
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] pending,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [PTR_W-1:0]   index,
  output logic               any
);

  always_comb begin
    logic [PTR_W-1:0] cand;
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    cand   = '0;
    // Offsets are added modulo 2**PTR_W, which gives the 7->0 wrap for free.
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = ptr + off[PTR_W-1:0];
      if (!any && pending[cand]) begin
        any           = 1'b1;
        index         = cand;
        onehot[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_request_arbiter.sv
// Round-robin arbiter producing a one-hot grant from edge-detected
// request events.
// Ports:
//   clk         : in       system clock, rising edge
//   rst         : in       asynchronous active-high reset
//   req [7:0]   : in       level request lines; a 0->1 change is one event
//   grant_ack   : in       consumer accepted the current grant
//   ovf_clr     : in       clear the sticky overflow flag
//   grant [7:0] : out      one-hot grant (or zero when idle)
//   grant_valid : out      grant holds a valid request
//   pending[7:0]: out      latched request events not yet granted
//   overflow    : out      sticky: a request event was lost
module onehot_request_arbiter #(
  parameter int NUM_REQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               grant_ack,
  input  logic               ovf_clr,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [NUM_REQ-1:0] pending,
  output logic               overflow
);
  import arb_pkg::*;

  state_t                   state_reg,    state_next;
  logic [NUM_REQ-1:0]       grant_reg,    grant_next;
  logic [PTR_W-1:0]         gidx_reg,     gidx_next;
  logic [PTR_W-1:0]         ptr_reg,      ptr_next;
  logic [NUM_REQ-1:0]       pending_reg,  pending_next;
  logic                     overflow_reg, overflow_next;
  logic [NUM_REQ-1:0]       req_q_reg;

  logic [NUM_REQ-1:0]       rise;
  logic [NUM_REQ-1:0]       clear_mask;
  logic                     ovf_event;
  logic [NUM_REQ-1:0]       pick_onehot;
  logic [PTR_W-1:0]         pick_index;
  logic                     pick_any;

  rr_pick u_rr_pick (
    .pending (pending_reg),
    .ptr     (ptr_reg),
    .onehot  (pick_onehot),
    .index   (pick_index),
    .any     (pick_any)
  );

  assign rise = req & ~req_q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      gidx_reg     <= '0;
      ptr_reg      <= '0;
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
      req_q_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      gidx_reg     <= gidx_next;
      ptr_reg      <= ptr_next;
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
      req_q_reg    <= req;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    gidx_next  = gidx_reg;
    ptr_next   = ptr_reg;
    clear_mask = '0;

    case (state_reg)
      IDLE: begin
        // Every grant is preceded by at least one cycle here, which caps
        // throughput at one grant per two cycles.
        if (pick_any) begin
          grant_next = pick_onehot;
          gidx_next  = pick_index;
          state_next = GRANT;
        end else begin
          grant_next = '0;
        end
      end
      GRANT: begin
        if (grant_ack) begin
          clear_mask = grant_reg;
          ptr_next   = gidx_reg + PTR_W'(1);
          grant_next = '0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase

    // A rise on the bit being retired this cycle re-arms it cleanly; a rise
    // on any bit still pending after the clear is a lost event.
    pending_next  = (pending_reg & ~clear_mask) | rise;
    ovf_event     = |(rise & pending_reg & ~clear_mask);
    overflow_next = ovf_event | (overflow_reg & ~ovf_clr);
  end

  assign grant       = grant_reg;
  assign grant_valid = (state_reg == GRANT);
  assign pending     = pending_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_onehot_request_arbiter.sv
// Self-checking bench for onehot_request_arbiter.
// Stimulus pushes expected grants into a queue; a monitor pops one each time
// a new grant appears and also checks grant invariants every cycle.
module tb_onehot_request_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = 8'h00;
  logic       grant_ack = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] grant;
  logic       grant_valid;
  logic [7:0] pending;
  logic       overflow;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  onehot_request_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant_ack   (grant_ack),
    .ovf_clr     (ovf_clr),
    .grant       (grant),
    .grant_valid (grant_valid),
    .pending     (pending),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h at %0t", name, act, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    logic       prev_valid;
    logic [7:0] held;
    prev_valid = 1'b0;
    held       = 8'h00;
    forever begin
      @(negedge clk);
      n_assert++;
      if ((grant_valid !== (grant != 8'h00)) || !$onehot0(grant)) begin
        n_fail++;
        $display("FAIL grant_invariant: grant=0x%0h valid=%0b at %0t", grant, grant_valid, $time);
      end
      if (grant_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_grant: got 0x%0h expected none at %0t", grant, $time);
        end else begin
          chk("grant_seq", {24'h0, grant}, {24'h0, exp_q.pop_front()});
        end
        held = grant;
      end else if (grant_valid) begin
        n_assert++;
        if (grant !== held) begin
          n_fail++;
          $display("FAIL grant_hold: got 0x%0h expected 0x%0h at %0t", grant, held, $time);
        end
      end
      prev_valid = grant_valid;
    end
  end

  initial begin
    // Reset acts without a clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_async_grant", {24'h0, grant}, 32'h0);
    chk("rst_async_valid", {31'h0, grant_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_pending", {24'h0, pending}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);

    // Single rise: pending next edge, grant the edge after, ack clears.
    cyc(1); req = 8'h01; exp_q.push_back(8'h01);
    cyc(1); chk("single_pending", {24'h0, pending}, 32'h01);
            chk("single_valid_early", {31'h0, grant_valid}, 32'h0);
            req = 8'h00;
    cyc(1); chk("single_grant", {24'h0, grant}, 32'h01);
            chk("single_valid", {31'h0, grant_valid}, 32'h1);
            grant_ack = 1'b1;
    cyc(1); chk("single_ack_pending", {24'h0, pending}, 32'h0);
            chk("single_ack_valid", {31'h0, grant_valid}, 32'h0);
            grant_ack = 1'b0;

    // All lines rise with ack tied high: 0x01..0x80, one every 2 cycles.
    rst = 1'b1;
    cyc(1); rst = 1'b0;
    req = 8'hFF; grant_ack = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h01 << i);
    cyc(16); chk("all_last_grant", {24'h0, grant}, 32'h80);
    cyc(1);  chk("all_pending", {24'h0, pending}, 32'h0);
             chk("all_overflow", {31'h0, overflow}, 32'h0);
             chk("all_queue_empty", exp_q.size(), 32'h0);
             grant_ack = 1'b0; req = 8'h00;

    // Wrap: grant bit 4 (ptr -> 5) with pending 0x41 -> 0x40 then 0x01.
    cyc(1); req = 8'h10;
            exp_q.push_back(8'h10); exp_q.push_back(8'h40); exp_q.push_back(8'h01);
    cyc(2); chk("wrap_first", {24'h0, grant}, 32'h10); req = 8'h51;
    cyc(1); chk("wrap_pending", {24'h0, pending}, 32'h51); grant_ack = 1'b1;
    cyc(1); chk("wrap_pending_41", {24'h0, pending}, 32'h41);
    cyc(1); chk("wrap_grant_40", {24'h0, grant}, 32'h40);
    cyc(1); chk("wrap_pending_01", {24'h0, pending}, 32'h01);
    cyc(1); chk("wrap_grant_01", {24'h0, grant}, 32'h01);
    cyc(1); chk("wrap_done", {24'h0, pending}, 32'h0);
            grant_ack = 1'b0; req = 8'h00;

    // Overflow while bit 0 is held; clear vs same-cycle set; rise in ack cycle.
    cyc(1); req = 8'h01;
            exp_q.push_back(8'h01); exp_q.push_back(8'h08); exp_q.push_back(8'h08);
    cyc(2); chk("ovf_hold_grant", {24'h0, grant}, 32'h01); req = 8'h09;
    cyc(1); req = 8'h01;
    cyc(1); req = 8'h09;
    cyc(1); chk("ovf_set", {31'h0, overflow}, 32'h1);
            chk("ovf_pending", {24'h0, pending}, 32'h09);
            chk("ovf_grant", {24'h0, grant}, 32'h01);
            req = 8'h01; ovf_clr = 1'b1;
    cyc(1); chk("ovf_clr", {31'h0, overflow}, 32'h0); req = 8'h09;
    cyc(1); chk("ovf_set_wins", {31'h0, overflow}, 32'h1);
            ovf_clr = 1'b0; grant_ack = 1'b1;
    cyc(1); chk("ovf_ack_pending", {24'h0, pending}, 32'h08); grant_ack = 1'b0;
    cyc(1); chk("ovf_grant_08", {24'h0, grant}, 32'h08); req = 8'h01; ovf_clr = 1'b1;
    cyc(1); ovf_clr = 1'b0; req = 8'h09; grant_ack = 1'b1;
    cyc(1); chk("ackrise_pending", {24'h0, pending}, 32'h08);
            chk("ackrise_no_ovf", {31'h0, overflow}, 32'h0);
            grant_ack = 1'b0;
    cyc(1); chk("ackrise_regrant", {24'h0, grant}, 32'h08); grant_ack = 1'b1;
    cyc(1); chk("ackrise_done", {24'h0, pending}, 32'h0);
            grant_ack = 1'b0; req = 8'h00;

    // Stall: no ack for 10 cycles while req[2] rises.
    cyc(1); req = 8'h02; exp_q.push_back(8'h02); exp_q.push_back(8'h04);
    cyc(2); chk("stall_grant", {24'h0, grant}, 32'h02); req = 8'h06;
    for (int i = 0; i < 10; i++) begin
      cyc(1); chk("stall_hold", {24'h0, grant}, 32'h02);
    end
    chk("stall_pending", {24'h0, pending}, 32'h06);
    grant_ack = 1'b1;
    cyc(1); chk("stall_ack_pending", {24'h0, pending}, 32'h04); grant_ack = 1'b0;
    cyc(1); chk("stall_next_grant", {24'h0, grant}, 32'h04); grant_ack = 1'b1;
    cyc(1); grant_ack = 1'b0; req = 8'h00;
            chk("stall_done", {24'h0, pending}, 32'h0);

    // Asynchronous reset mid-grant, req held across release.
    cyc(1); req = 8'h10; exp_q.push_back(8'h10);
    cyc(2); chk("areset_pre_grant", {24'h0, grant}, 32'h10);
    #2 rst = 1'b1;
    #1;
    chk("areset_grant", {24'h0, grant}, 32'h0);
    chk("areset_valid", {31'h0, grant_valid}, 32'h0);
    chk("areset_pending", {24'h0, pending}, 32'h0);
    chk("areset_overflow", {31'h0, overflow}, 32'h0);
    exp_q.push_back(8'h10);
    @(negedge clk); rst = 1'b0;
    cyc(1); chk("release_pending", {24'h0, pending}, 32'h10);
            chk("release_valid_early", {31'h0, grant_valid}, 32'h0);
    cyc(1); chk("release_grant", {24'h0, grant}, 32'h10);
            grant_ack = 1'b1;
    cyc(1); grant_ack = 1'b0; req = 8'h00;
    cyc(2); chk("final_queue_empty", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
